// File: rtl/race_timer_pkg.sv
// rtl/race_timer_pkg.sv - shared race state encoding and sizing helpers
package race_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int unsigned TIME_W_DEF = 16;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/race_timer_tick_gen.sv
// rtl/race_timer_tick_gen.sv - divides clk down to one tick per TICK_HZ time unit
module race_timer_tick_gen
  import race_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 65_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CW  = cnt_width(DIV);
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TERM);

  // Held at zero while disabled so every race and every lap starts a full period.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/race_timer.sv
// rtl/race_timer.sv - race sequencer: lap timing, checkpoint-armed crossings, lap counting
module race_timer
  import race_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 65_000_000,
  parameter int unsigned TICK_HZ = 100,
  parameter int unsigned TIME_W  = TIME_W_DEF,
  parameter int unsigned LAPS    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish_line,
  input  logic              checkpoint,
  output logic [TIME_W-1:0] bin_out,
  output logic              lap_finished,
  output logic [3:0]        lap_count,
  output logic              running,
  output logic              race_over
);

  localparam logic [TIME_W-1:0] TIME_MAX = '1;
  localparam logic [3:0]        LAST_LAP = 4'(LAPS - 1);

  state_e            state_q, state_d;
  logic [TIME_W-1:0] bin_q, bin_d;
  logic [3:0]        lap_cnt_q, lap_cnt_d;
  logic              lap_fin_q, armed_q, armed_d, fl_q, cp_q;
  logic              fl_rise, cp_rise, is_run, valid, tick;

  assign fl_rise = finish_line & ~fl_q;
  assign cp_rise = checkpoint & ~cp_q;
  assign is_run  = (state_q == ST_RUNNING);
  // Uses last cycle's armed so a checkpoint rising with the finish line only arms the next lap.
  assign valid   = is_run & fl_rise & armed_q;

  race_timer_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (is_run),
    .clr  (valid),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    lap_cnt_d = lap_cnt_q;
    armed_d   = armed_q;
    case (state_q)
      ST_IDLE: begin
        bin_d     = '0;
        lap_cnt_d = '0;
        armed_d   = 1'b0;
        if (start) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (valid) begin
          bin_d     = '0;
          lap_cnt_d = lap_cnt_q + 4'd1;
          armed_d   = 1'b0;
          if (lap_cnt_q == LAST_LAP) state_d = ST_DONE;
        end else if (tick && (bin_q != TIME_MAX)) begin
          bin_d = bin_q + 1'b1;
        end
        if (cp_rise) armed_d = 1'b1;
      end
      ST_DONE: begin
        armed_d = 1'b0;
        if (start) begin
          state_d   = ST_IDLE;
          lap_cnt_d = '0;
          bin_d     = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      lap_cnt_q <= '0;
      lap_fin_q <= 1'b0;
      armed_q   <= 1'b0;
      fl_q      <= 1'b0;
      cp_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      lap_cnt_q <= lap_cnt_d;
      lap_fin_q <= valid;
      armed_q   <= armed_d;
      fl_q      <= finish_line;
      cp_q      <= checkpoint;
    end
  end

  assign bin_out      = bin_q;
  assign lap_finished = lap_fin_q;
  assign lap_count    = lap_cnt_q;
  assign running      = is_run;
  assign race_over    = (state_q == ST_DONE);

endmodule

// File: tb/tb_race_timer.sv
// tb/tb_race_timer.sv - directed bench for race_timer with a lap-pulse scoreboard
module tb_race_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, fl, cp;
  logic [15:0] bin_a;
  logic        lf_a, run_a, over_a;
  logic [3:0]  lc_a;

  logic        rst_nb, start_b, fl_b, cp_b;
  logic [3:0]  bin_b;
  logic        lf_b, run_b, over_b;
  logic [3:0]  lc_b;

  race_timer #(.CLK_HZ(1000), .TICK_HZ(100), .TIME_W(16), .LAPS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .finish_line(fl), .checkpoint(cp),
    .bin_out(bin_a), .lap_finished(lf_a), .lap_count(lc_a), .running(run_a), .race_over(over_a)
  );

  race_timer #(.CLK_HZ(1000), .TICK_HZ(100), .TIME_W(4), .LAPS(3)) dut_b (
    .clk(clk), .rst_n(rst_nb), .start(start_b), .finish_line(fl_b), .checkpoint(cp_b),
    .bin_out(bin_b), .lap_finished(lf_b), .lap_count(lc_b), .running(run_b), .race_over(over_b)
  );

  int checks = 0;
  int passes = 0;
  int pulses = 0;
  int sb[$];
  int exp_lap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic do_lap(input int lap_no);
    cp = 1'b1;
    step(2);
    cp = 1'b0;
    step(5);
    fl = 1'b1;
    sb.push_back(lap_no);
    step(1);
    fl = 1'b0;
    step(2);
  endtask

  // Every lap_finished pulse must match a crossing the stimulus declared valid.
  always @(negedge clk) begin
    if (lf_a === 1'b1) begin
      pulses++;
      check("sb_pulse_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_lap = sb.pop_front();
        check("sb_lap_count", 32'(lc_a), exp_lap);
        check("sb_bin_zero", 32'(bin_a), 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b1; fl = 1'b1; cp = 1'b0;
    rst_nb = 1'b0; start_b = 1'b0; fl_b = 1'b0; cp_b = 1'b0;

    // 1: reset dominates start and finish_line
    step(3);
    check("rst_bin", 32'(bin_a), 0);
    check("rst_lf", 32'(lf_a), 0);
    check("rst_lc", 32'(lc_a), 0);
    check("rst_run", 32'(run_a), 0);
    check("rst_over", 32'(over_a), 0);
    start = 1'b0; fl = 1'b0; rst_n = 1'b1;
    step(2);
    check("idle_run", 32'(run_a), 0);

    // 2: free running, no crossings
    start_pulse();
    step(250);
    check("t2_bin", 32'(bin_a), 25);
    check("t2_run", 32'(run_a), 1);
    check("t2_pulses", 32'(pulses), 0);

    // 3: unarmed crossing ignored, then one armed crossing at 40
    reset_pulse();
    check("t3_rst_bin", 32'(bin_a), 0);
    check("t3_rst_run", 32'(run_a), 0);
    start_pulse();
    step(3); fl = 1'b1; step(3); fl = 1'b0; step(3);
    check("t3_unarmed_lc", 32'(lc_a), 0);
    check("t3_unarmed_pulses", 32'(pulses), 0);
    cp = 1'b1; step(2); cp = 1'b0;
    k = 0;
    while (bin_a != 16'd40 && k < 1000) begin
      step(1);
      k++;
    end
    check("t3_bin40", 32'(bin_a), 40);
    fl = 1'b1;
    sb.push_back(1);
    step(1);
    check("t3_lf", 32'(lf_a), 1);
    check("t3_bin0", 32'(bin_a), 0);
    check("t3_lc", 32'(lc_a), 1);
    step(1);
    check("t3_lf_one_cycle", 32'(lf_a), 0);
    fl = 1'b0;
    step(2);
    check("t3_pulses", 32'(pulses), 1);

    // 4: finish_line held high yields a single lap
    cp = 1'b1; step(1); cp = 1'b0; step(3);
    fl = 1'b1;
    sb.push_back(2);
    step(50);
    fl = 1'b0;
    step(2);
    check("t4_pulses", 32'(pulses), 2);
    check("t4_lc", 32'(lc_a), 2);
    check("t4_run", 32'(run_a), 1);

    // 5: full race, mid-race start ignored, coincident cp/fl arms only
    reset_pulse();
    start_pulse();
    step(20);
    start_pulse();
    check("t5_start_ignored_run", 32'(run_a), 1);
    check("t5_start_ignored_lc", 32'(lc_a), 0);
    cp = 1'b1; fl = 1'b1;
    step(1);
    check("t5_coincident_lf", 32'(lf_a), 0);
    step(1);
    cp = 1'b0; fl = 1'b0;
    step(2);
    check("t5_coincident_lc", 32'(lc_a), 0);
    fl = 1'b1;
    sb.push_back(1);
    step(1);
    fl = 1'b0;
    check("t5_armed_lap1", 32'(lc_a), 1);
    step(3);
    do_lap(2);
    do_lap(3);
    check("t5_lc3", 32'(lc_a), 3);
    check("t5_over", 32'(over_a), 1);
    check("t5_run0", 32'(run_a), 0);
    check("t5_bin0", 32'(bin_a), 0);
    step(100);
    check("t5_frozen_bin", 32'(bin_a), 0);
    check("t5_frozen_lc", 32'(lc_a), 3);
    cp = 1'b1; step(2); cp = 1'b0; step(2);
    fl = 1'b1; step(2); fl = 1'b0; step(2);
    check("t5_pulses", 32'(pulses), 5);
    check("t5_done_lc", 32'(lc_a), 3);
    start_pulse();
    check("t5_idle_lc", 32'(lc_a), 0);
    check("t5_idle_over", 32'(over_a), 0);
    check("t5_idle_run", 32'(run_a), 0);
    check("t5_idle_bin", 32'(bin_a), 0);

    // 6: narrow counter saturates; reset mid-race clears everything
    rst_nb = 1'b1;
    step(1);
    start_b = 1'b1; step(1); start_b = 1'b0;
    step(200);
    check("t6_sat_bin", 32'(bin_b), 15);
    check("t6_run", 32'(run_b), 1);
    check("t6_lf", 32'(lf_b), 0);
    rst_nb = 1'b0;
    step(1);
    check("t6_rst_bin", 32'(bin_b), 0);
    check("t6_rst_run", 32'(run_b), 0);
    check("t6_rst_lc", 32'(lc_b), 0);
    check("t6_rst_over", 32'(over_b), 0);
    check("t6_rst_lf", 32'(lf_b), 0);

    step(2);
    check("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
